safe_entry_ctrl: RTL and testbench



---
 rtl/safe_entry_ctrl_pkg.sv | 28 ++
 rtl/safe_entry_ctrl_if.sv | 26 ++
 rtl/safe_entry_ctrl_scramble.sv | 23 ++
 rtl/safe_entry_ctrl.sv | 147 ++++++++++++++
 tb/tb_safe_entry_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/safe_entry_ctrl_pkg.sv
// Shared types and constants for the safe entry controller and its scrambler.
package safe_pkg;

  localparam int unsigned CHAR_W    = 7;
  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned SLOT_AW   = $clog2(NUM_SLOTS);
  localparam int unsigned MAGIC_W   = CHAR_W * NUM_SLOTS;

  localparam logic [MAGIC_W-1:0] EXPECTED = 56'd3008192072309708;

  // Buffer slot feeding each magic field; element [0] is the most-significant field.
  localparam logic [NUM_SLOTS-1:0][SLOT_AW-1:0] MAGIC_ORDER =
    {3'd1, 3'd7, 3'd3, 3'd4, 3'd2, 3'd6, 3'd5, 3'd0};

  // Low bounds of the magic fields [55:A], [A-1:B], [B-1:C], [C-1:0] that get reordered.
  localparam int unsigned PERM_A_LO = 42;
  localparam int unsigned PERM_B_LO = 22;
  localparam int unsigned PERM_C_LO = 10;

  typedef enum logic [2:0] {
    StCollect,
    StCheck,
    StReport,
    StOpen,
    StLockout
  } state_e;

endpackage

// File: rtl/safe_entry_ctrl_if.sv
// Character input, attempt result and safe status signals of the entry controller.
interface safe_entry_ctrl_if;
  import safe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W-1:0] in_data;
  logic              in_abort;
  logic              relock;
  logic              result_valid;
  logic              result_open;
  logic              open_safe;
  logic              locked;
  logic [1:0]        fail_count;

  modport master (
    output in_valid, in_data, in_abort, relock,
    input  in_ready, result_valid, result_open, open_safe, locked, fail_count
  );

  modport slave (
    input  in_valid, in_data, in_abort, relock,
    output in_ready, result_valid, result_open, open_safe, locked, fail_count
  );

endinterface

// File: rtl/safe_entry_ctrl_scramble.sv
// Combinational gather-and-permute of the entry buffer, compared against the combination.
module safe_scramble
  import safe_pkg::*;
(
  input  logic [NUM_SLOTS-1:0][CHAR_W-1:0] i_slots,
  output logic                             o_match
);

  logic [MAGIC_W-1:0] w_magic;
  logic [MAGIC_W-1:0] w_permuted;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_magic
    assign w_magic[MAGIC_W-1-g*CHAR_W -: CHAR_W] = i_slots[MAGIC_ORDER[g]];
  end

  assign w_permuted = {w_magic[PERM_C_LO-1:0],
                       w_magic[PERM_A_LO-1:PERM_B_LO],
                       w_magic[PERM_B_LO-1:PERM_C_LO],
                       w_magic[MAGIC_W-1:PERM_A_LO]};

  assign o_match = (w_permuted == EXPECTED);

endmodule

// File: rtl/safe_entry_ctrl.sv
// Safe passcode sequencer: collects 8 characters, checks them, manages open state and fails.
// Optional lockout after repeated failures is built when SAFE_LOCKOUT_EN is defined.
module safe_entry_ctrl
  import safe_pkg::*;
#(
  parameter int unsigned STRIDE         = 5,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  safe_entry_ctrl_if.slave io_bus
);

  localparam logic [SLOT_AW-1:0] STRIDE_L = SLOT_AW'(STRIDE % NUM_SLOTS);
  localparam logic [SLOT_AW-1:0] LAST_CNT = SLOT_AW'(NUM_SLOTS - 1);
  localparam logic [1:0]         FAIL_MAX = 2'(MAX_FAILS);

  state_e                          r_state, w_state_d;
  logic [SLOT_AW-1:0]              r_ptr, w_ptr_d;
  logic [SLOT_AW-1:0]              r_count, w_count_d;
  logic [1:0]                      r_fail, w_fail_d, w_fail_inc;
  logic                            r_match;
  logic [NUM_SLOTS-1:0][CHAR_W-1:0] r_slots;
  logic                            w_match;
  logic                            w_accept;
  logic                            w_in_ready, w_result_valid, w_result_open;
  logic                            w_open_safe, w_locked;

`ifdef SAFE_LOCKOUT_EN
  localparam int unsigned   LOCK_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
  logic [LOCK_W-1:0] r_lock_cnt, w_lock_d;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^LOCKOUT_CYCLES;
`endif

  safe_scramble u_scramble (
    .i_slots (r_slots),
    .o_match (w_match)
  );

  assign w_fail_inc = (r_fail == FAIL_MAX) ? r_fail : r_fail + 2'd1;

  always_comb begin
    w_state_d      = r_state;
    w_ptr_d        = r_ptr;
    w_count_d      = r_count;
    w_fail_d       = r_fail;
    w_accept       = 1'b0;
    w_in_ready     = 1'b0;
    w_result_valid = 1'b0;
    w_result_open  = 1'b0;
    w_open_safe    = 1'b0;
    w_locked       = 1'b0;
`ifdef SAFE_LOCKOUT_EN
    w_lock_d       = r_lock_cnt;
`endif
    unique case (r_state)
      StCollect: begin
        w_in_ready = !io_bus.in_abort;
        if (io_bus.in_abort) begin
          w_ptr_d   = '0;
          w_count_d = '0;
        end else if (io_bus.in_valid) begin
          w_accept  = 1'b1;
          w_ptr_d   = r_ptr + STRIDE_L;
          w_count_d = r_count + 1'b1;
          if (r_count == LAST_CNT) w_state_d = StCheck;
        end
      end
      StCheck: w_state_d = StReport;
      StReport: begin
        w_result_valid = 1'b1;
        w_result_open  = r_match;
        w_ptr_d        = '0;
        w_count_d      = '0;
        if (r_match) begin
          w_fail_d  = '0;
          w_state_d = StOpen;
        end else begin
          w_fail_d  = w_fail_inc;
          w_state_d = StCollect;
`ifdef SAFE_LOCKOUT_EN
          if (w_fail_inc == FAIL_MAX) begin
            w_state_d = StLockout;
            w_lock_d  = LOCK_LOAD;
          end
`endif
        end
      end
      StOpen: begin
        w_open_safe = 1'b1;
        if (io_bus.relock) w_state_d = StCollect;
      end
`ifdef SAFE_LOCKOUT_EN
      StLockout: begin
        w_locked = 1'b1;
        if (r_lock_cnt == '0) begin
          w_fail_d  = '0;
          w_state_d = StCollect;
        end else begin
          w_lock_d = r_lock_cnt - 1'b1;
        end
      end
`endif
      default: w_state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StCollect;
      r_ptr   <= '0;
      r_count <= '0;
      r_fail  <= '0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_count <= w_count_d;
      r_fail  <= w_fail_d;
      if (r_state == StCheck) r_match <= w_match;
    end
  end

`ifdef SAFE_LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (rst) r_lock_cnt <= '0;
    else     r_lock_cnt <= w_lock_d;
  end
`endif

  // Buffer contents need no reset; only the pointer and count define a valid entry.
  always_ff @(posedge clk) begin
    if (w_accept) r_slots[r_ptr] <= io_bus.in_data;
  end

  assign io_bus.in_ready     = w_in_ready;
  assign io_bus.result_valid = w_result_valid;
  assign io_bus.result_open  = w_result_open;
  assign io_bus.open_safe    = w_open_safe;
  assign io_bus.locked       = w_locked;
  assign io_bus.fail_count   = r_fail;

endmodule

// File: tb/tb_safe_entry_ctrl.sv
// Directed and randomized bench for safe_entry_ctrl; follows SAFE_LOCKOUT_EN like the RTL.
module tb_safe_entry_ctrl;

`ifdef SAFE_LOCKOUT_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif
  localparam int MaxFails = 3;
  localparam int LockLen  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_fails = 0;

  logic [6:0] good [8] = '{7'h37, 7'h4C, 7'h6F, 7'h58, 7'h25, 7'h2A, 7'h5F, 7'h78};
  logic [6:0] bad  [8] = '{7'h41, 7'h41, 7'h41, 7'h41, 7'h41, 7'h41, 7'h41, 7'h41};

  always #5 clk = ~clk;

  safe_entry_ctrl_if bus ();

  safe_entry_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  // Reference: character i lands in slot (5*i mod 8); magic gathers slots in a fixed order.
  function automatic bit model_match(input logic [6:0] ch [8]);
    logic [6:0]  slot [8];
    int          order [8] = '{0, 5, 6, 2, 4, 3, 7, 1};
    logic [55:0] magic;
    logic [55:0] perm;
    for (int i = 0; i < 8; i++) slot[(i * 5) % 8] = ch[i];
    magic = '0;
    for (int i = 0; i < 8; i++) magic = (magic << 7) | {49'b0, slot[order[i]]};
    perm = ((magic & 56'h3FF) << 46) | (((magic >> 22) & 56'hFFFFF) << 26)
         | (((magic >> 10) & 56'hFFF) << 14) | (magic >> 42);
    return perm == 56'd3008192072309708;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_fc(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_abort = 1'b0;
    bus.relock   = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic send_chars(input logic [6:0] ch [8], input int n, input int max_gap);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        idle();
        #1;
        chk_bit("ready_gap", bus.in_ready, 1'b1);
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = ch[i];
      #1;
      chk_bit("ready_accept", bus.in_ready, 1'b1);
      tick();
    end
    idle();
  endtask

  // Called in the cycle after the 8th accept; returns in the first cycle after REPORT.
  task automatic finish_attempt(input logic [6:0] ch [8], output bit matched);
    bit m;
    bit lock_exp;
    m = model_match(ch);
    #1;
    chk_bit("ready_check", bus.in_ready, 1'b0);
    chk_bit("rv_check", bus.result_valid, 1'b0);
    tick();
    #1;
    chk_bit("result_valid", bus.result_valid, 1'b1);
    chk_bit("result_open", bus.result_open, m);
    chk_bit("ready_report", bus.in_ready, 1'b0);
    if (m) m_fails = 0;
    else if (m_fails < MaxFails) m_fails++;
    lock_exp = LockEn && !m && (m_fails == MaxFails);
    tick();
    #1;
    chk_bit("open_safe", bus.open_safe, m);
    chk_bit("locked", bus.locked, lock_exp);
    chk_bit("ready_after", bus.in_ready, !m && !lock_exp);
    chk_bit("rv_pulse", bus.result_valid, 1'b0);
    chk_fc("fail_count", bus.fail_count, 2'(m_fails));
    matched = m;
  endtask

  task automatic relock_safe(input int hold);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_abort = 1'b1;
      bus.in_data  = 7'h41;
      #1;
      chk_bit("open_hold", bus.open_safe, 1'b1);
      chk_bit("ready_open", bus.in_ready, 1'b0);
      tick();
    end
    idle();
    bus.relock = 1'b1;
    tick();
    bus.relock = 1'b0;
    #1;
    chk_bit("open_relock", bus.open_safe, 1'b0);
    chk_bit("ready_relock", bus.in_ready, 1'b1);
  endtask

  // Counts locked cycles while offering a character every cycle; bounded.
  task automatic wait_lockout();
    int  n;
    bit  expect_lock;
    expect_lock = LockEn && (m_fails == MaxFails);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.locked !== 1'b1) break;
      n++;
      chk_bit("ready_lockout", bus.in_ready, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 7'h41;
      tick();
    end
    idle();
    #1;
    chk_int("lock_len", n, expect_lock ? LockLen : 0);
    if (expect_lock) m_fails = 0;
    chk_fc("fail_after_lock", bus.fail_count, 2'(m_fails));
    chk_bit("ready_after_lock", bus.in_ready, 1'b1);
  endtask

  task automatic do_abort(input logic [6:0] ch [8], input int n);
    send_chars(ch, n, 1);
    bus.in_valid = 1'b1;
    bus.in_abort = 1'b1;
    bus.in_data  = ch[n];
    #1;
    chk_bit("ready_abort", bus.in_ready, 1'b0);
    tick();
    idle();
    #1;
    chk_bit("ready_post_abort", bus.in_ready, 1'b1);
    chk_fc("fail_abort", bus.fail_count, 2'(m_fails));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    #1;
    m_fails = 0;
    chk_bit("rst_ready", bus.in_ready, 1'b1);
    chk_bit("rst_locked", bus.locked, 1'b0);
    chk_bit("rst_open", bus.open_safe, 1'b0);
    chk_bit("rst_rv", bus.result_valid, 1'b0);
    chk_fc("rst_fail", bus.fail_count, 2'd0);
  endtask

  task automatic attempt(input logic [6:0] ch [8], input int max_gap, output bit matched);
    send_chars(ch, 8, max_gap);
    finish_attempt(ch, matched);
  endtask

  initial begin
    bit m;
    idle();
    rst = 1'b1;
    repeat (2) tick();
    #1;
    chk_bit("reset_ready", bus.in_ready, 1'b1);
    chk_bit("reset_rv", bus.result_valid, 1'b0);
    chk_bit("reset_ropen", bus.result_open, 1'b0);
    chk_bit("reset_open", bus.open_safe, 1'b0);
    chk_bit("reset_locked", bus.locked, 1'b0);
    chk_fc("reset_fail", bus.fail_count, 2'd0);
    rst = 1'b0;
    tick();

    // Correct entry, then relock.
    attempt(good, 0, m);
    chk_bit("good_opens", m, 1'b1);
    relock_safe(3);

    // Wrong entry.
    attempt(bad, 0, m);
    wait_lockout();

    // Failure count clears on a match; a following failure counts from zero.
    attempt(bad, 1, m);
    wait_lockout();
    attempt(good, 1, m);
    relock_safe(1);
    attempt(bad, 0, m);
    wait_lockout();

    // Reach MAX_FAILS: lockout when built in, saturation otherwise.
    attempt(bad, 0, m);
    wait_lockout();
    attempt(bad, 0, m);
    wait_lockout();
    attempt(bad, 0, m);
    wait_lockout();

    // Abort after 5 characters, then the correct entry still opens.
    do_abort(good, 5);
    attempt(good, 0, m);
    relock_safe(0);

    // Reset mid-entry and in OPEN.
    send_chars(good, 4, 0);
    pulse_reset();
    attempt(good, 0, m);
    pulse_reset();

    // Reset mid-lockout.
    for (int i = 0; i < MaxFails; i++) begin
      attempt(bad, 0, m);
      if (i < MaxFails - 1) wait_lockout();
    end
    repeat (5) tick();
    chk_bit("locked_before_rst", bus.locked, LockEn);
    pulse_reset();

    // Randomized entries with gaps, aborts, relocks and lockouts.
    for (int it = 0; it < 30; it++) begin
      logic [6:0] ch [8];
      logic [6:0] junk [8];
      if ($urandom_range(3, 0) == 0) ch = good;
      else for (int i = 0; i < 8; i++) ch[i] = 7'($urandom);
      if ($urandom_range(4, 0) == 0) begin
        for (int i = 0; i < 8; i++) junk[i] = 7'($urandom);
        do_abort(junk, int'($urandom_range(7, 1)));
      end
      attempt(ch, 2, m);
      if (m) relock_safe(int'($urandom_range(3, 0)));
      else wait_lockout();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
